// File: rtl/memoria_requisicoes_andares_pkg.sv
// Shared constants and helpers for the elevator request memory.
// Optional feature macro: CANCELA_CHAMADA_EN (see top module).
package pacote_elevador;

    localparam logic SUBINDO     = 1'b1;
    localparam logic DESCENDO    = 1'b0;
    localparam int   MAX_ANDARES = 16;

    function automatic logic andar_valido(input int idx, input int n);
        return (idx >= 0) && (idx < n);
    endfunction

endpackage

// File: rtl/memoria_requisicoes_andares_seletor.sv
// SCAN next-floor selector: keep going in the current direction, else reverse.
// Purely combinational; the current floor is never chosen as a target.
module seletor_proximo_andar_scan
    import pacote_elevador::*;
#(
    parameter  int NUM_ANDARES = 4,
    localparam int ANDAR_W     = (NUM_ANDARES > 1) ? $clog2(NUM_ANDARES) : 1
) (
    input  logic [NUM_ANDARES-1:0] mapa,
    input  logic [ANDAR_W-1:0]     andar_atual,
    input  logic                   direcao,
    output logic [ANDAR_W-1:0]     alvo,
    output logic                   valido
);

    logic [ANDAR_W-1:0] alvo_acima;
    logic [ANDAR_W-1:0] alvo_abaixo;
    logic               tem_acima;
    logic               tem_abaixo;

    // Descending scan keeps the lowest floor above; ascending scan the highest below.
    always_comb begin
        alvo_acima  = '0;
        alvo_abaixo = '0;
        tem_acima   = 1'b0;
        tem_abaixo  = 1'b0;
        for (int i = NUM_ANDARES - 1; i >= 0; i--) begin
            if (mapa[i] && (i > int'(andar_atual))) begin
                alvo_acima = ANDAR_W'(i);
                tem_acima  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_ANDARES; i++) begin
            if (mapa[i] && (i < int'(andar_atual))) begin
                alvo_abaixo = ANDAR_W'(i);
                tem_abaixo  = 1'b1;
            end
        end
    end

    always_comb begin
        alvo   = andar_atual;
        valido = 1'b0;
        if (direcao == SUBINDO) begin
            if (tem_acima) begin
                alvo   = alvo_acima;
                valido = 1'b1;
            end else if (tem_abaixo) begin
                alvo   = alvo_abaixo;
                valido = 1'b1;
            end
        end else begin
            if (tem_abaixo) begin
                alvo   = alvo_abaixo;
                valido = 1'b1;
            end else if (tem_acima) begin
                alvo   = alvo_acima;
                valido = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memoria_requisicoes_andares.sv
// Per-floor request memory with door-dwell clearing and registered SCAN target.
// Define CANCELA_CHAMADA_EN to add the cancelar/andar_cancelar request-cancel port.
module memoria_requisicoes_andares
    import pacote_elevador::*;
#(
    parameter  int NUM_ANDARES = 4,
    parameter  int TEMPO_PORTA = 25,
    localparam int ANDAR_W     = (NUM_ANDARES > 1) ? $clog2(NUM_ANDARES) : 1
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic [ANDAR_W-1:0]     andar_atual,
    input  logic [ANDAR_W-1:0]     andar_pessoa,
    input  logic                   subir_pessoa,
    input  logic [ANDAR_W-1:0]     andar_chamada,
    input  logic                   botao_chamada,
`ifdef CANCELA_CHAMADA_EN
    input  logic                   cancelar,
    input  logic [ANDAR_W-1:0]     andar_cancelar,
`endif
    input  logic                   movimento_elevador,
    input  logic                   indicador_porta_aberta,
    output logic [NUM_ANDARES-1:0] requisicoes,
    output logic                   leitura_endereco,
    output logic                   atendido,
    output logic [ANDAR_W-1:0]     proximo_andar,
    output logic                   proximo_valido
);

    localparam logic [7:0] TEMPO = 8'(TEMPO_PORTA);
    localparam logic [NUM_ANDARES-1:0] UM = NUM_ANDARES'(1);

    logic [7:0]             cnt;
    logic [7:0]             cnt_prox;
    logic [ANDAR_W-1:0]     andar_ant;
    logic                   porta_mesmo;
    logic                   conclui;
    logic [NUM_ANDARES-1:0] mask_atual;
    logic [NUM_ANDARES-1:0] mask_set;
    logic [NUM_ANDARES-1:0] mask_clr;
    logic [NUM_ANDARES-1:0] req_prox;
    logic [ANDAR_W-1:0]     alvo;
    logic                   valido;

    assign porta_mesmo = indicador_porta_aberta && (andar_atual == andar_ant);

    always_comb begin
        mask_atual = '0;
        if (andar_valido(int'(andar_atual), NUM_ANDARES)) begin
            mask_atual = UM << andar_atual;
        end
    end

    assign leitura_endereco = |(requisicoes & mask_atual);

    // Counter saturates so a door held open never produces a second pulse.
    always_comb begin
        cnt_prox = 8'd0;
        if (porta_mesmo) begin
            cnt_prox = (cnt == TEMPO) ? cnt : cnt + 8'd1;
        end
    end

    assign conclui = porta_mesmo && (cnt_prox == TEMPO) && (cnt != TEMPO)
                     && leitura_endereco;

    // A request for the floor being served with the door open is dropped.
    always_comb begin
        mask_set = '0;
        if (subir_pessoa && andar_valido(int'(andar_pessoa), NUM_ANDARES)
            && !(indicador_porta_aberta && (andar_pessoa == andar_atual))) begin
            mask_set = mask_set | (UM << andar_pessoa);
        end
        if (botao_chamada && andar_valido(int'(andar_chamada), NUM_ANDARES)
            && !(indicador_porta_aberta && (andar_chamada == andar_atual))) begin
            mask_set = mask_set | (UM << andar_chamada);
        end
    end

    always_comb begin
        mask_clr = conclui ? mask_atual : '0;
`ifdef CANCELA_CHAMADA_EN
        if (cancelar && andar_valido(int'(andar_cancelar), NUM_ANDARES)) begin
            mask_clr = mask_clr | (UM << andar_cancelar);
        end
`endif
    end

    assign req_prox = (requisicoes | mask_set) & ~mask_clr;

    seletor_proximo_andar_scan #(
        .NUM_ANDARES(NUM_ANDARES)
    ) u_seletor (
        .mapa       (requisicoes),
        .andar_atual(andar_atual),
        .direcao    (movimento_elevador),
        .alvo       (alvo),
        .valido     (valido)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            requisicoes    <= '0;
            atendido       <= 1'b0;
            cnt            <= 8'd0;
            proximo_andar  <= '0;
            proximo_valido <= 1'b0;
        end else begin
            requisicoes    <= req_prox;
            atendido       <= conclui;
            cnt            <= cnt_prox;
            proximo_andar  <= alvo;
            proximo_valido <= valido;
        end
    end

    always_ff @(posedge clock_in) begin
        andar_ant <= andar_atual;
    end

endmodule

// File: tb/tb_memoria_requisicoes_andares.sv
// Bench for memoria_requisicoes_andares: 4-floor and 6-floor instances,
// table vectors through a scoreboard queue plus dwell/reset sequences.
module tb_memoria_requisicoes_andares;

    typedef struct {
        logic [8*12-1:0] nome;
        bit sel6;
        bit rst;
        int at;
        bit mov;
        bit porta;
        bit sp;
        int pes;
        bit bc;
        int cha;
        int e_req;
        bit e_atd;
        int e_prox;
        bit e_val;
        bit e_le;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0] at4 = '0, pes4 = '0, cha4 = '0;
    logic       sp4 = 1'b0, bc4 = 1'b0, mov4 = 1'b1, porta4 = 1'b0;
    logic [3:0] req4;
    logic       le4, atd4, val4;
    logic [1:0] prox4;

    logic [2:0] at6 = '0, pes6 = '0, cha6 = '0;
    logic       sp6 = 1'b0, bc6 = 1'b0, mov6 = 1'b1, porta6 = 1'b0;
    logic [5:0] req6;
    logic       le6, atd6, val6;
    logic [2:0] prox6;

`ifdef CANCELA_CHAMADA_EN
    logic       canc4 = 1'b0, canc6 = 1'b0;
    logic [1:0] acanc4 = '0;
    logic [2:0] acanc6 = '0;
`endif

    int total = 0;
    int bad = 0;
    vec_t tab4[$];
    vec_t tab6[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    memoria_requisicoes_andares #(.NUM_ANDARES(4), .TEMPO_PORTA(25)) u4 (
        .clock_in(clk), .reset(rst),
        .andar_atual(at4), .andar_pessoa(pes4), .subir_pessoa(sp4),
        .andar_chamada(cha4), .botao_chamada(bc4),
`ifdef CANCELA_CHAMADA_EN
        .cancelar(canc4), .andar_cancelar(acanc4),
`endif
        .movimento_elevador(mov4), .indicador_porta_aberta(porta4),
        .requisicoes(req4), .leitura_endereco(le4), .atendido(atd4),
        .proximo_andar(prox4), .proximo_valido(val4)
    );

    memoria_requisicoes_andares #(.NUM_ANDARES(6), .TEMPO_PORTA(3)) u6 (
        .clock_in(clk), .reset(rst),
        .andar_atual(at6), .andar_pessoa(pes6), .subir_pessoa(sp6),
        .andar_chamada(cha6), .botao_chamada(bc6),
`ifdef CANCELA_CHAMADA_EN
        .cancelar(canc6), .andar_cancelar(acanc6),
`endif
        .movimento_elevador(mov6), .indicador_porta_aberta(porta6),
        .requisicoes(req6), .leitura_endereco(le6), .atendido(atd6),
        .proximo_andar(prox6), .proximo_valido(val6)
    );

    function automatic vec_t mk(
        input logic [8*12-1:0] nome, input bit sel6, input bit rst_v,
        input int at, input bit mov, input bit porta,
        input bit sp, input int pes, input bit bc, input int cha,
        input int e_req, input bit e_atd, input int e_prox,
        input bit e_val, input bit e_le);
        vec_t v;
        v.nome = nome; v.sel6 = sel6; v.rst = rst_v;
        v.at = at; v.mov = mov; v.porta = porta;
        v.sp = sp; v.pes = pes; v.bc = bc; v.cha = cha;
        v.e_req = e_req; v.e_atd = e_atd; v.e_prox = e_prox;
        v.e_val = e_val; v.e_le = e_le;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aplica(input vec_t v);
        vec_t e;
        rst = v.rst;
        sp4 = 1'b0; bc4 = 1'b0; sp6 = 1'b0; bc6 = 1'b0;
        if (v.sel6) begin
            at6 = 3'(v.at); mov6 = v.mov; porta6 = v.porta;
            sp6 = v.sp; pes6 = 3'(v.pes); bc6 = v.bc; cha6 = 3'(v.cha);
        end else begin
            at4 = 2'(v.at); mov4 = v.mov; porta4 = v.porta;
            sp4 = v.sp; pes4 = 2'(v.pes); bc4 = v.bc; cha4 = 2'(v.cha);
        end
        sb.push_back(v);
        tick();
        e = sb.pop_front();
        if (e.sel6) begin
            chk($sformatf("%0s.req", e.nome), 32'(req6), 32'(e.e_req));
            chk($sformatf("%0s.atd", e.nome), 32'(atd6), 32'(e.e_atd));
            chk($sformatf("%0s.prox", e.nome), 32'(prox6), 32'(e.e_prox));
            chk($sformatf("%0s.val", e.nome), 32'(val6), 32'(e.e_val));
            chk($sformatf("%0s.le", e.nome), 32'(le6), 32'(e.e_le));
        end else begin
            chk($sformatf("%0s.req", e.nome), 32'(req4), 32'(e.e_req));
            chk($sformatf("%0s.atd", e.nome), 32'(atd4), 32'(e.e_atd));
            chk($sformatf("%0s.prox", e.nome), 32'(prox4), 32'(e.e_prox));
            chk($sformatf("%0s.val", e.nome), 32'(val4), 32'(e.e_val));
            chk($sformatf("%0s.le", e.nome), 32'(le4), 32'(e.e_le));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //             nome          s6 r  at m p  sp pes bc cha  req  a prox v le
        tab4.push_back(mk("reset",     0, 1, 0, 1, 0, 0, 0, 0, 0, 'h0, 0, 0, 0, 0));
        tab4.push_back(mk("set_p3",    0, 0, 0, 1, 0, 1, 3, 0, 0, 'h8, 0, 0, 0, 0));
        tab4.push_back(mk("prox_up3",  0, 0, 0, 1, 0, 0, 0, 0, 0, 'h8, 0, 3, 1, 0));
        tab4.push_back(mk("porta_ign", 0, 0, 1, 1, 1, 0, 0, 1, 1, 'h8, 0, 3, 1, 0));
        tab4.push_back(mk("porta_fech",0, 0, 1, 1, 0, 0, 0, 1, 1, 'hA, 0, 3, 1, 1));
        tab4.push_back(mk("scan_up",   0, 0, 2, 1, 0, 0, 0, 0, 0, 'hA, 0, 3, 1, 0));
        tab4.push_back(mk("scan_dn",   0, 0, 2, 0, 0, 0, 0, 0, 0, 'hA, 0, 1, 1, 0));
        tab4.push_back(mk("topo_up",   0, 0, 3, 1, 0, 0, 0, 0, 0, 'hA, 0, 1, 1, 1));
        tab4.push_back(mk("base_dn",   0, 0, 0, 0, 0, 0, 0, 0, 0, 'hA, 0, 1, 1, 0));
        tab4.push_back(mk("dup_p3",    0, 0, 3, 1, 0, 1, 3, 0, 0, 'hA, 0, 1, 1, 1));
        tab4.push_back(mk("ambos_0",   0, 0, 2, 1, 0, 1, 0, 1, 0, 'hB, 0, 3, 1, 0));
        tab4.push_back(mk("reset2",    0, 1, 2, 1, 0, 0, 0, 0, 0, 'h0, 0, 0, 0, 0));
        tab4.push_back(mk("vazio",     0, 0, 2, 1, 0, 0, 0, 0, 0, 'h0, 0, 2, 0, 0));
        tab4.push_back(mk("vazio_at1", 0, 0, 1, 1, 0, 0, 0, 0, 0, 'h0, 0, 1, 0, 0));
        tab4.push_back(mk("set_atual", 0, 0, 2, 1, 0, 0, 0, 1, 2, 'h4, 0, 2, 0, 1));
        tab4.push_back(mk("so_atual",  0, 0, 2, 1, 0, 0, 0, 0, 0, 'h4, 0, 2, 0, 1));

        tab6.push_back(mk("r6",        1, 1, 0, 1, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0));
        tab6.push_back(mk("fora7",     1, 0, 0, 1, 0, 1, 7, 0, 0, 'h00, 0, 0, 0, 0));
        tab6.push_back(mk("dois5",     1, 0, 0, 1, 0, 1, 5, 1, 2, 'h24, 0, 0, 0, 0));
        tab6.push_back(mk("scan6up",   1, 0, 3, 1, 0, 0, 0, 0, 0, 'h24, 0, 5, 1, 0));
        tab6.push_back(mk("scan6dn",   1, 0, 3, 0, 0, 0, 0, 0, 0, 'h24, 0, 2, 1, 0));
        tab6.push_back(mk("fora6",     1, 0, 3, 0, 0, 0, 0, 1, 6, 'h24, 0, 2, 1, 0));
        tab6.push_back(mk("rst6",      1, 1, 3, 1, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0));
        tab6.push_back(mk("set04",     1, 0, 3, 1, 0, 1, 4, 1, 0, 'h11, 0, 3, 0, 0));
        tab6.push_back(mk("dw0a",      1, 0, 0, 1, 1, 0, 0, 0, 0, 'h11, 0, 4, 1, 1));
        tab6.push_back(mk("dw0b",      1, 0, 0, 1, 1, 0, 0, 0, 0, 'h11, 0, 4, 1, 1));
        tab6.push_back(mk("dw0c",      1, 0, 0, 1, 1, 0, 0, 0, 0, 'h11, 0, 4, 1, 1));
        tab6.push_back(mk("rst_meio",  1, 1, 0, 1, 1, 0, 0, 0, 0, 'h00, 0, 0, 0, 0));
        tab6.push_back(mk("pos_rst",   1, 0, 0, 1, 1, 1, 4, 0, 0, 'h10, 0, 0, 0, 0));
        tab6.push_back(mk("set0",      1, 0, 0, 1, 0, 0, 0, 1, 0, 'h11, 0, 4, 1, 1));
        tab6.push_back(mk("d1",        1, 0, 0, 1, 1, 0, 0, 0, 0, 'h11, 0, 4, 1, 1));
        tab6.push_back(mk("d2",        1, 0, 0, 1, 1, 0, 0, 0, 0, 'h11, 0, 4, 1, 1));
        tab6.push_back(mk("d3",        1, 0, 0, 1, 1, 0, 0, 0, 0, 'h10, 1, 4, 1, 0));
        tab6.push_back(mk("d4",        1, 0, 0, 1, 1, 0, 0, 0, 0, 'h10, 0, 4, 1, 0));

        tick();
        for (int i = 0; i < tab4.size(); i++) aplica(tab4[i]);

        // Full 25-cycle dwell at floor 2, with a hall call on floor 0 on the clearing cycle.
        rst = 1'b0; at4 = 2'd2; mov4 = 1'b1; porta4 = 1'b1;
        sp4 = 1'b0; cha4 = 2'd0;
        for (int k = 1; k <= 30; k++) begin
            bc4 = (k == 25);
            tick();
            chk($sformatf("dwell_atd_k%0d", k), 32'(atd4), 32'(k == 25));
            if (k == 24) chk("dwell_req_k24", 32'(req4), 32'h4);
            if (k == 25) chk("dwell_req_k25", 32'(req4), 32'h1);
        end
        bc4 = 1'b0;

        // One cycle short of the dwell leaves the request pending.
        porta4 = 1'b0; bc4 = 1'b1; cha4 = 2'd2;
        tick();
        chk("curto_set", 32'(req4), 32'h5);
        bc4 = 1'b0; porta4 = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk($sformatf("curto_atd_k%0d", k), 32'(atd4), 32'h0);
        end
        porta4 = 1'b0;
        tick();
        tick();
        chk("curto_req", 32'(req4), 32'h5);
        chk("curto_atd", 32'(atd4), 32'h0);

        for (int i = 0; i < tab6.size(); i++) aplica(tab6[i]);

`ifdef CANCELA_CHAMADA_EN
        sp6 = 1'b0; bc6 = 1'b0; porta6 = 1'b0; at6 = 3'd0;
        canc6 = 1'b1; acanc6 = 3'd4; sp6 = 1'b1; pes6 = 3'd4;
        tick();
        chk("canc_vence", 32'(req6), 32'h00);
        chk("canc_atd", 32'(atd6), 32'h0);
        canc6 = 1'b0;
        tick();
        chk("canc_reset", 32'(req6), 32'h10);
        sp6 = 1'b0; canc6 = 1'b1; acanc6 = 3'd7;
        tick();
        chk("canc_fora", 32'(req6), 32'h10);
        canc6 = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
